// File: rtl/myadder_stream_alu.sv
`timescale 1ns/1ps
// myadder_stream_alu
//   Lane-wise streaming ALU between two AXI4-Stream ports. Each accepted beat
//   carries its own copy of ctrl_constant/ctrl_mode. Every C_LANE_WIDTH lane
//   is combined with the constant as add-wrap, add-saturate (unsigned),
//   subtract-wrap or pass-through. The result goes through a three-register
//   pipeline into a first-word-fall-through output buffer.
//   A credit counter limits accepted input to what the buffer can hold, so
//   back-pressure on m_axis never causes loss.
//
// Ports
//   s_axis_aclk, s_axis_aresetn    clock, asynchronous active-low reset
//   ctrl_constant [LW], ctrl_mode  operand and operation, captured per beat
//   stat_clear                     synchronous clear of the stat_* outputs
//   s_axis_t{valid,ready,data,keep,last}   input stream
//   m_axis_t{valid,ready,data,keep,last}   output stream
//   stat_beat_count, stat_pkt_count        output beats / tlast beats
//   stat_sat                       sticky saturation flag
module myadder_stream_alu #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_LANE_WIDTH       = 32,
  parameter int C_FIFO_DEPTH       = 32
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_aresetn,
  input  logic [C_LANE_WIDTH-1:0]         ctrl_constant,
  input  logic [1:0]                      ctrl_mode,
  input  logic                            stat_clear,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [31:0]                     stat_beat_count,
  output logic [31:0]                     stat_pkt_count,
  output logic                            stat_sat
);

  localparam int W  = C_AXIS_TDATA_WIDTH;
  localparam int LW = C_LANE_WIDTH;
  localparam int KW = W / 8;
  localparam int NL = W / LW;
  localparam int LB = LW / 8;
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = W + KW + 1;

  localparam logic [1:0] MODE_ADD_WRAP = 2'b00;
  localparam logic [1:0] MODE_ADD_SAT  = 2'b01;
  localparam logic [1:0] MODE_SUB_WRAP = 2'b10;

  if (!(LW == 8 || LW == 16 || LW == 32 || LW == 64)) begin : g_bad_lane
    $fatal(1, "C_LANE_WIDTH must be 8, 16, 32 or 64");
  end
  if (W < LW || (W % LW) != 0) begin : g_bad_width
    $fatal(1, "C_AXIS_TDATA_WIDTH must be a non-zero multiple of C_LANE_WIDTH");
  end
  if (C_FIFO_DEPTH < 4 || C_FIFO_DEPTH > 256 ||
      (C_FIFO_DEPTH & (C_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "C_FIFO_DEPTH must be a power of two in 4..256");
  end

  // Raw lane operation; bit LW is the carry-out of the add modes.
  function automatic logic [LW:0] lane_op(input logic [LW-1:0] a,
                                          input logic [LW-1:0] c,
                                          input logic [1:0]    mode);
    logic [LW:0] r;
    case (mode)
      MODE_ADD_WRAP, MODE_ADD_SAT: r = {1'b0, a} + {1'b0, c};
      MODE_SUB_WRAP:               r = {1'b0, a - c};
      default:                     r = {1'b0, a};
    endcase
    return r;
  endfunction

  // Unsigned clamp: a carry-out in saturating mode pins the lane to all ones.
  function automatic logic [LW-1:0] sat_lane(input logic [LW:0] r,
                                             input logic        sat_en);
    return (sat_en && r[LW]) ? {LW{1'b1}} : r[LW-1:0];
  endfunction

  logic          s_fire, m_fire;
  logic          tready_r;
  logic [CW-1:0] credit, credit_nxt;

  logic [W-1:0]    data_p0;
  logic [KW-1:0]   keep_p0;
  logic            last_p0;
  logic [LW-1:0]   const_p0;
  logic [1:0]      mode_p0;
  logic            vld_p0;

  logic [LW-1:0]   res_p1 [NL];
  logic            carry_p1 [NL];
  logic [NL-1:0]   lane_sat_p1;
  logic [KW-1:0]   keep_p1;
  logic            last_p1;
  logic [1:0]      mode_p1;
  logic            vld_p1;

  logic [LW-1:0]   lane_p2 [NL];
  logic [W-1:0]    data_p2;
  logic [KW-1:0]   keep_p2;
  logic            last_p2;
  logic            sat_p2;
  logic            vld_p2;

  logic [BW-1:0]   mem [C_FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  assign s_axis_tready = tready_r;
  assign m_axis_tvalid = (count != '0);
  assign s_fire        = s_axis_tvalid & tready_r;
  assign m_fire        = m_axis_tvalid & m_axis_tready;
  // Credit covers beats in the pipeline as well as in the buffer, so the
  // buffer cannot overflow however long m_axis_tready stays low.
  assign credit_nxt    = credit + CW'(s_fire) - CW'(m_fire);

  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = mem[rd_ptr];

  // ---- stage p0: capture the beat together with its own ctrl settings ----
  always_ff @(posedge s_axis_aclk) begin
    data_p0  <= s_axis_tdata;
    keep_p0  <= s_axis_tkeep;
    last_p0  <= s_axis_tlast;
    const_p0 <= ctrl_constant;
    mode_p0  <= ctrl_mode;
    keep_p1  <= keep_p0;
    last_p1  <= last_p0;
    mode_p1  <= mode_p0;
    keep_p2  <= keep_p1;
    last_p2  <= last_p1;
    sat_p2   <= (mode_p1 == MODE_ADD_SAT) && (|lane_sat_p1);
  end

  for (genvar g = 0; g < NL; g++) begin : g_lane
    // ---- stage p1: raw add/sub with carry ----
    // ---- stage p2: saturation applied ----
    always_ff @(posedge s_axis_aclk) begin
      {carry_p1[g], res_p1[g]} <= lane_op(data_p0[g*LW +: LW], const_p0, mode_p0);
      lane_p2[g]               <= sat_lane({carry_p1[g], res_p1[g]}, mode_p1 == MODE_ADD_SAT);
    end
    // A lane counts toward stat_sat only if its lowest byte is kept.
    assign lane_sat_p1[g]       = carry_p1[g] & keep_p1[g*LB];
    assign data_p2[g*LW +: LW]  = lane_p2[g];
  end

  // ---- buffer write: stage p2 result enters the FWFT buffer ----
  always_ff @(posedge s_axis_aclk) begin
    if (vld_p2) mem[wr_ptr] <= {last_p2, keep_p2, data_p2};
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      tready_r        <= 1'b0;
      credit          <= '0;
      vld_p0          <= 1'b0;
      vld_p1          <= 1'b0;
      vld_p2          <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      stat_beat_count <= '0;
      stat_pkt_count  <= '0;
      stat_sat        <= 1'b0;
    end else begin
      credit   <= credit_nxt;
      tready_r <= (credit_nxt < CW'(C_FIFO_DEPTH));
      vld_p0   <= s_fire;
      vld_p1   <= vld_p0;
      vld_p2   <= vld_p1;
      if (vld_p2) wr_ptr <= wr_ptr + AW'(1);
      if (m_fire) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(vld_p2) - CW'(m_fire);

      if (stat_clear) begin
        stat_beat_count <= '0;
        stat_pkt_count  <= '0;
      end else if (m_fire) begin
        stat_beat_count <= stat_beat_count + 32'd1;
        if (m_axis_tlast) stat_pkt_count <= stat_pkt_count + 32'd1;
      end

      // Set has priority over clear so a saturation is never lost.
      if (vld_p2 && sat_p2) stat_sat <= 1'b1;
      else if (stat_clear)  stat_sat <= 1'b0;
    end
  end

endmodule

// File: tb/tb_myadder_stream_alu.sv
`timescale 1ns/1ps
// Testbench for myadder_stream_alu: random and directed stimulus, expected
// beats produced by a lane-arithmetic model and checked by an output monitor.
module tb_myadder_stream_alu;

  localparam int W     = 64;
  localparam int LW    = 32;
  localparam int KW    = W / 8;
  localparam int NL    = W / LW;
  localparam int DEPTH = 32;
  localparam longint unsigned MOD  = 64'h1_0000_0000;
  localparam longint unsigned MAXV = MOD - 1;

  typedef logic [W+KW:0] beat_t;

  logic          clk = 1'b0;
  logic          s_axis_aresetn = 1'b1;
  logic [LW-1:0] ctrl_constant;
  logic [1:0]    ctrl_mode;
  logic          stat_clear;
  logic          s_axis_tvalid, s_axis_tready;
  logic [W-1:0]  s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic          m_axis_tvalid, m_axis_tready;
  logic [W-1:0]  m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [31:0]   stat_beat_count, stat_pkt_count;
  logic          stat_sat;

  beat_t exp_q[$];
  int    n_pass  = 0;
  int    n_total = 0;
  logic  exp_sat = 1'b0;
  int    rdy_mode = 0;   // 0: ready held 1, 1: random 50%, 2: held 0
  int    cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  myadder_stream_alu #(
    .C_AXIS_TDATA_WIDTH(W),
    .C_LANE_WIDTH      (LW),
    .C_FIFO_DEPTH      (DEPTH)
  ) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (s_axis_aresetn),
    .ctrl_constant  (ctrl_constant),
    .ctrl_mode      (ctrl_mode),
    .stat_clear     (stat_clear),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast),
    .stat_beat_count(stat_beat_count),
    .stat_pkt_count (stat_pkt_count),
    .stat_sat       (stat_sat)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Reference: plain integer arithmetic per lane.
  task automatic push_exp(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l,
                          input logic [LW-1:0] c, input logic [1:0] m);
    logic [W-1:0] r;
    longint unsigned a, cc, v;
    r  = '0;
    cc = 64'(c);
    for (int i = 0; i < NL; i++) begin
      a = 64'(d[i*LW +: LW]);
      case (m)
        2'd0: v = (a + cc) % MOD;
        2'd1: begin
          v = a + cc;
          if (v > MAXV) begin
            v = MAXV;
            if (k[i*(LW/8)]) exp_sat = 1'b1;
          end
        end
        2'd2:    v = (a + MOD - cc) % MOD;
        default: v = a;
      endcase
      r[i*LW +: LW] = v[LW-1:0];
    end
    exp_q.push_back({l, k, r});
  endtask

  task automatic send(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l,
                      input logic [LW-1:0] c, input logic [1:0] m);
    int w = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
    ctrl_constant = c; ctrl_mode = m;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && w < 2000) begin @(negedge clk); w++; end
    if (!s_axis_tready) begin
      n_total++;
      $display("FAIL send_timeout: s_axis_tready=%0b, required 1", s_axis_tready);
    end else push_exp(d, k, l, c, m);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    // Disturb ctrl right after acceptance: the beat must keep its own copy.
    ctrl_constant = $urandom;
    ctrl_mode     = 2'($urandom);
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && w < 5000) begin @(negedge clk); w++; end
    if (w >= 5000) begin
      n_total++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // m_axis_tready driver
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(1, 0));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Output monitor
  initial begin
    beat_t got, held;
    logic  stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      got = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (!s_axis_aresetn) stall = 1'b0;
      else begin
        if (stall) chk("hold_stable", 128'({m_axis_tvalid, got}), 128'({1'b1, held}));
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_beat: got %0h, required no output", got);
          end else chk("out_beat", 128'(got), 128'(exp_q.pop_front()));
        end
        stall = m_axis_tvalid && !m_axis_tready;
        held  = got;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, t0, w;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    ctrl_constant = '0; ctrl_mode = 2'b00; stat_clear = 1'b0;
    #2 s_axis_aresetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tready", 128'(s_axis_tready), 128'(0));
    chk("reset_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("reset_beats",  128'(stat_beat_count), 128'(0));
    chk("reset_pkts",   128'(stat_pkt_count), 128'(0));
    chk("reset_sat",    128'(stat_sat), 128'(0));
    s_axis_aresetn = 1'b1;
    #1 chk("tready_before_edge", 128'(s_axis_tready), 128'(0));
    @(posedge clk); #1;
    chk("tready_first_edge", 128'(s_axis_tready), 128'(1));

    // Latency and add-wrap of 0xFFFFFFFF + 1
    send(64'h00000005_FFFFFFFF, 8'hFF, 1'b1, 32'd1, 2'b00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("lat_n2_tvalid", 128'(m_axis_tvalid), 128'(0));
    @(posedge clk); #1;
    chk("lat_n3_tvalid", 128'(m_axis_tvalid), 128'(1));
    drain();
    chk("wrap_no_sat", 128'(stat_sat), 128'(0));

    // Saturation gated by the lane's lowest tkeep bit
    send(64'h00000001_FFFFFFF8, 8'hFE, 1'b0, 32'h10, 2'b01);
    drain();
    chk("sat_keep0", 128'(stat_sat), 128'(0));
    send(64'h00000001_FFFFFFF8, 8'hFF, 1'b1, 32'h10, 2'b01);
    drain();
    chk("sat_keep1", 128'(stat_sat), 128'(1));
    stat_clear = 1'b1; @(posedge clk); #1; stat_clear = 1'b0;
    exp_sat = 1'b0;
    chk("sat_cleared", 128'(stat_sat), 128'(0));

    // Subtract-wrap and pass-through
    send(64'h7FFFFFFF_00000003, 8'hFF, 1'b0, 32'd5, 2'b10);
    send(64'h7FFFFFFF_00000003, 8'hFF, 1'b1, 32'd5, 2'b11);
    drain();

    // Back-to-back throughput, mode changes every beat
    t0 = cyc;
    for (int i = 0; i < 50; i++)
      send({$urandom, $urandom}, 8'($urandom), 1'(i % 2), $urandom, 2'(i));
    chk("throughput_cycles", 128'(cyc - t0), 128'(50));
    drain();
    chk("sat_after_modes", 128'(stat_sat), 128'(exp_sat));

    // Fill with output stalled: exactly DEPTH beats accepted
    rdy_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    acc = 0;
    s_axis_tdata = {$urandom, $urandom}; s_axis_tkeep = 8'($urandom); s_axis_tlast = 1'b0;
    ctrl_constant = $urandom; ctrl_mode = 2'($urandom);
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        push_exp(s_axis_tdata, s_axis_tkeep, s_axis_tlast, ctrl_constant, ctrl_mode);
        acc++;
      end
      @(posedge clk); #1;
      s_axis_tdata = {$urandom, $urandom}; s_axis_tkeep = 8'($urandom);
      s_axis_tlast = 1'($urandom); ctrl_constant = $urandom; ctrl_mode = 2'($urandom);
    end
    s_axis_tvalid = 1'b0;
    chk("fill_accepted", 128'(acc), 128'(DEPTH));
    chk("fill_tready_low", 128'(s_axis_tready), 128'(0));
    chk("fill_tvalid", 128'(m_axis_tvalid), 128'(1));
    rdy_mode = 0;
    drain();

    // Random traffic: 10000 beats, 100 packets
    stat_clear = 1'b1; @(posedge clk); #1; stat_clear = 1'b0;
    exp_sat = 1'b0;
    rdy_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      while ($urandom_range(1, 0) == 0) begin @(posedge clk); #1; end
      send({$urandom, $urandom}, 8'($urandom), 1'((i % 100) == 99), $urandom, 2'($urandom));
    end
    rdy_mode = 0;
    drain();
    chk("rand_beats", 128'(stat_beat_count), 128'(10000));
    chk("rand_pkts",  128'(stat_pkt_count), 128'(100));
    chk("rand_sat",   128'(stat_sat), 128'(exp_sat));

    // Clear in the same cycle as an output handshake wins
    send(64'h12345678_9ABCDEF0, 8'hFF, 1'b1, 32'd0, 2'b11);
    w = 0;
    do begin @(negedge clk); w++; end while (!m_axis_tvalid && w < 20);
    stat_clear = 1'b1;
    @(posedge clk); #1;
    stat_clear = 1'b0;
    chk("clear_vs_incr_beats", 128'(stat_beat_count), 128'(0));
    chk("clear_vs_incr_pkts",  128'(stat_pkt_count), 128'(0));
    drain();

    // Reset with 10 beats buffered
    rdy_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++)
      send({$urandom, $urandom}, 8'hFF, 1'(i == 9), $urandom, 2'($urandom));
    repeat (6) @(posedge clk);
    #1;
    chk("prereset_tvalid", 128'(m_axis_tvalid), 128'(1));
    #1 s_axis_aresetn = 1'b0;
    #1;
    chk("reset_async_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("reset_async_tready", 128'(s_axis_tready), 128'(0));
    exp_q.delete();
    exp_sat = 1'b0;
    @(negedge clk);
    s_axis_aresetn = 1'b1;
    @(posedge clk); #1;
    chk("rerelease_tready", 128'(s_axis_tready), 128'(1));
    chk("rerelease_beats",  128'(stat_beat_count), 128'(0));
    chk("rerelease_pkts",   128'(stat_pkt_count), 128'(0));
    chk("rerelease_sat",    128'(stat_sat), 128'(0));
    rdy_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("no_spurious_out", 128'(m_axis_tvalid), 128'(0));
    for (int i = 0; i < 3; i++)
      send({$urandom, $urandom}, 8'($urandom), 1'b1, $urandom, 2'(i));
    drain();
    chk("post_reset_beats", 128'(stat_beat_count), 128'(3));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/myadder_stream_alu.md
MYADDER_STREAM_ALU -- requirements
Module: myadder_stream_alu

Interface
REQ-001 Parameter C_AXIS_TDATA_WIDTH, default 512, stream data width in bits, multiple of C_LANE_WIDTH.
REQ-002 Parameter C_LANE_WIDTH, default 32, lane width; legal values 8, 16, 32, 64.
REQ-003 Parameter C_FIFO_DEPTH, default 32, output buffer depth in beats; power of two, 4..256.
REQ-004 Illegal parameter combinations SHALL fail at elaboration.
REQ-005 s_axis_aclk  in  1  the only clock; both stream sides and all control/status are synchronous to it.
REQ-006 s_axis_aresetn  in  1  asynchronous, active-low reset.
REQ-007 ctrl_constant  in  C_LANE_WIDTH  operand applied to every lane.
REQ-008 ctrl_mode  in  2  00 add-wrap, 01 add-saturate (unsigned), 10 subtract-wrap (lane - constant), 11 pass-through.
REQ-009 stat_clear  in  1  synchronous clear of all status outputs.
REQ-010 s_axis_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  1/1/W/W/8/1  input AXI4-Stream.
REQ-011 m_axis_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/W/W/8/1  output AXI4-Stream.
REQ-012 stat_beat_count  out  32  output beats transferred.
REQ-013 stat_pkt_count  out  32  output beats transferred with tlast=1.
REQ-014 stat_sat  out  1  sticky: at least one lane saturated since last clear.

Function
REQ-015 Input beat accepted on rising edge with s_axis_tvalid & s_axis_tready; no beat SHALL ever be dropped or duplicated.
REQ-016 ctrl_constant and ctrl_mode SHALL be captured with each accepted beat; later changes never affect beats already accepted.
REQ-017 Per lane i: result = op(tdata[i*LW +: LW], constant) per ctrl_mode; wrap modes modulo 2^LW; mode 01 clamps to 2^LW-1 on carry-out.
REQ-018 tkeep and tlast SHALL pass unchanged, aligned with their data beat.
REQ-019 Pipeline: accept at edge N -> stage1 at N+1 -> result at N+2 -> written to first-word-fall-through buffer; m_axis_tvalid=1 after edge N+3 when buffer was empty.
REQ-020 Credit counter (0..C_FIFO_DEPTH) SHALL track beats in pipeline plus buffer: +1 on input accept, -1 on output accept, unchanged when both occur in the same cycle.
REQ-021 s_axis_tready SHALL be a registered signal equal to (next credit count < C_FIFO_DEPTH); buffer SHALL never overflow regardless of m_axis_tready pattern.
REQ-022 Full throughput: with m_axis_tready held 1, one beat per cycle sustained indefinitely.
REQ-023 m_axis_tvalid, once asserted, SHALL stay asserted with tdata/tkeep/tlast stable until m_axis_tready=1.
REQ-024 stat_beat_count +1 per output handshake; stat_pkt_count +1 per output handshake with tlast=1; both wrap 2^32-1 -> 0.
REQ-025 stat_sat set when an accepted beat in mode 01 clamps any lane whose lowest-byte tkeep bit is 1; evaluated at stage2.
REQ-026 stat_clear=1: counters load 0 (clear wins over same-cycle increment); stat_sat loads 0 unless a set occurs that cycle (set wins).
REQ-027 Empty buffer: m_axis_tvalid=0; m_axis_tready value ignored.

Reset
REQ-028 While s_axis_aresetn=0: s_axis_tready=0, m_axis_tvalid=0, credit=0, buffer empty, pipeline valids 0, stat_* = 0; m_axis_tdata/tkeep/tlast undefined.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight and buffered beats immediately (asynchronously).
REQ-030 s_axis_tready SHALL rise at the first rising edge after reset deassertion; no output beat before an input beat is accepted.

Verification
REQ-031 LW=32, mode 00, constant 1, lane 0xFFFFFFFF -> output lane 0x00000000, stat_sat stays 0.
REQ-032 LW=8, mode 01, constant 0x10, lane 0xF8 tkeep=1 -> lane 0xFF, stat_sat=1; same with tkeep=0 -> stat_sat stays 0.
REQ-033 Mode 10, constant 5, lane 3 -> 0xFFFFFFFE; mode 11 -> data unchanged; mode switched every beat, each beat uses its own captured mode.
REQ-034 Depth 32, m_axis_tready=0, continuous tvalid -> exactly 32 beats accepted, then tready=0; release m_axis_tready -> 32 beats out in order, no loss.
REQ-035 Random tvalid/tready (50%), 10000 beats, 100 packets -> scoreboard match, stat_beat_count=10000, stat_pkt_count=100; stat_clear same cycle as handshake -> count 0.
REQ-036 Reset asserted with 10 beats buffered -> m_axis_tvalid=0 immediately; after release, tready=1 at first edge, counters 0.
